// File: rtl/arm_pkg.sv
// Shared core types and constants for the ARM-style pipeline front end.
package arm_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] PC_INCR = 32'd4;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FLUSH = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequences r15, runs the imem req/ack handshake and
// buffers one fetched word for decode.
module fetch_unit
  import arm_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] PC_out,
  output logic [XLEN-1:0] PC_next,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target
);

  fetch_state_t    r_state;
  fetch_state_t    w_state_nxt;
  logic            r_imem_req;
  logic [XLEN-1:0] r_imem_addr;
  logic [XLEN-1:0] r_instr;
  logic            r_instr_valid;

  logic            w_load_addr;
  logic            w_capture;
  logic            w_valid_nxt;
  logic            w_req_nxt;
  logic [XLEN-1:0] w_pc_next;

  // State and registered outputs; imem_req drops as soon as rst rises.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_BOOT;
      r_imem_req    <= 1'b0;
      r_imem_addr   <= RESET_PC;
      r_instr       <= '0;
      r_instr_valid <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_imem_req    <= w_req_nxt;
      r_instr_valid <= w_valid_nxt;
      if (w_load_addr) r_imem_addr <= w_pc_next;
      if (w_capture)   r_instr     <= imem_rdata;
    end
  end

  // Next-state logic; w_load_addr marks every edge that enters S_FETCH.
  always_comb begin
    w_state_nxt = r_state;
    w_load_addr = 1'b0;
    w_capture   = 1'b0;
    w_valid_nxt = r_instr_valid;
    case (r_state)
      S_BOOT: begin
        w_state_nxt = S_FETCH;
        w_load_addr = 1'b1;
      end
      S_FETCH: begin
        if (branch_taken) begin
          if (imem_ack) begin
            w_state_nxt = S_FETCH;
            w_load_addr = 1'b1;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end else if (imem_ack) begin
          w_state_nxt = S_HOLD;
          w_capture   = 1'b1;
          w_valid_nxt = 1'b1;
        end
      end
      S_FLUSH: begin
        if (imem_ack) begin
          w_state_nxt = S_FETCH;
          w_load_addr = 1'b1;
        end
      end
      S_HOLD: begin
        if (branch_taken || instr_ready) begin
          w_state_nxt = S_FETCH;
          w_load_addr = 1'b1;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_BOOT;
        w_valid_nxt = 1'b0;
      end
    endcase
  end

  // PC_next is the only combinational output; a branch always overrides.
  always_comb begin
    w_pc_next = PC_out;
    case (r_state)
      S_BOOT: w_pc_next = RESET_PC;
      S_FETCH: begin
        if (branch_taken)  w_pc_next = branch_target;
        else if (imem_ack) w_pc_next = PC_out + PC_INCR;
      end
      S_FLUSH, S_HOLD: begin
        if (branch_taken) w_pc_next = branch_target;
      end
      default: w_pc_next = RESET_PC;
    endcase
  end

  assign w_req_nxt   = (w_state_nxt == S_FETCH) || (w_state_nxt == S_FLUSH);
  assign PC_next     = w_pc_next;
  assign imem_req    = r_imem_req;
  assign imem_addr   = r_imem_addr;
  assign instr       = r_instr;
  assign instr_valid = r_instr_valid;

endmodule
